// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the 15-bit ALU: one instruction per 2 cycles (3 for MUL/DIV).
// instr_ready is high only in IDLE, so there is no back-to-back accept; results commit at the end of each EX cycle.
module alu_sequencer #(
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_srca,
  input  logic [AW-1:0] instr_srcb,
  input  logic [15:0]   instr_imm,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic [2:0]    alu_command,
  input  logic [14:0]   alu_result,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [15:0]   wb_data,
  output logic          div_err,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;

  localparam logic [2:0] CMD_MP0 = 3'd3;
  localparam logic [2:0] CMD_MP1 = 3'd4;
  localparam logic [2:0] CMD_DV0 = 3'd5;
  localparam logic [2:0] CMD_DV1 = 3'd6;

  typedef enum logic [1:0] {IDLE, EX1, EX2} state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [15:0]   imm_q;
  logic [15:0]   opa_q, opb_q;
  logic [15:0]   regs [NREGS];

  logic          accept;
  logic          set_err;
  logic          div_zero;
  logic [AW-1:0] dst_inc;
  logic [15:0]   alu_word;

  assign instr_ready = (state == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign div_zero    = (opb_q[15:1] == '0);
  assign dst_inc     = dst_q + 1'b1;
  // Parity bit makes the stored 16-bit word odd parity.
  assign alu_word    = {alu_result, ~^alu_result};
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      div_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= instr_op;
        dst_q <= instr_dst;
        imm_q <= instr_imm;
        opa_q <= regs[instr_srca];
        opb_q <= regs[instr_srcb];
      end
      if (wb_valid) begin
        regs[wb_addr] <= wb_data;
      end
      if (set_err) begin
        div_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    alu_a       = '0;
    alu_b       = '0;
    alu_command = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    set_err     = 1'b0;
    // Reset suppresses every output so a mid-operation reset cannot commit a write.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            state_nxt = EX1;
          end
        end
        EX1: begin
          state_nxt = IDLE;
          case (op_q)
            OP_ADD, OP_SUB, OP_AND: begin
              alu_a       = opa_q;
              alu_b       = opb_q;
              alu_command = op_q;
              wb_valid    = 1'b1;
              wb_addr     = dst_q;
              wb_data     = alu_word;
            end
            OP_MUL: begin
              alu_a       = opa_q;
              alu_b       = opb_q;
              alu_command = CMD_MP0;
              wb_valid    = 1'b1;
              wb_addr     = dst_q;
              wb_data     = alu_word;
              state_nxt   = EX2;
            end
            OP_DIV: begin
              wb_valid  = 1'b1;
              wb_addr   = dst_q;
              state_nxt = EX2;
              if (div_zero) begin
                wb_data = 16'hFFFE;
                set_err = 1'b1;
              end else begin
                alu_a       = opa_q;
                alu_b       = opb_q;
                alu_command = CMD_DV0;
                wb_data     = alu_word;
              end
            end
            OP_LDI: begin
              wb_valid = 1'b1;
              wb_addr  = dst_q;
              wb_data  = imm_q;
            end
            default: begin
              state_nxt = IDLE;
            end
          endcase
        end
        EX2: begin
          state_nxt = IDLE;
          wb_valid  = 1'b1;
          wb_addr   = dst_inc;
          if (op_q == OP_MUL) begin
            alu_a       = opa_q;
            alu_b       = opb_q;
            alu_command = CMD_MP1;
            wb_data     = alu_word;
          end else if (div_zero) begin
            wb_data = opa_q;
          end else begin
            alu_a       = opa_q;
            alu_b       = opb_q;
            alu_command = CMD_DV1;
            wb_data     = alu_word;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU stub plus a register-file model driven by directed and random instructions.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = '0, instr_dst = '0, instr_srca = '0, instr_srcb = '0;
  logic [15:0] instr_imm = '0;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_command;
  logic [14:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        div_err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] oa [3], ob [3], owd [3];
  logic [2:0]  oc [3], owa [3];
  logic        owv [3], ordy [3];
  int          nex;

  logic [15:0] rm [8];
  logic        merr;

  alu_sequencer #(.NREGS(8)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst), .instr_srca(instr_srca),
    .instr_srcb(instr_srcb), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_command(alu_command), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .div_err(div_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] alu_fn(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    int unsigned x, y, p;
    x = int'(a[15:1]);
    y = int'(b[15:1]);
    p = x * y;
    case (c)
      3'd0: return 15'(x + y);
      3'd1: return 15'(x - y);
      3'd2: return 15'(x & y);
      3'd3: return 15'(p);
      3'd4: return 15'(p >> 15);
      3'd5: return (y != 0) ? 15'(x / y) : 15'h7FFF;
      3'd6: return (y != 0) ? 15'(x % y) : 15'(x);
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic [15:0] par(input logic [14:0] r);
    logic even;
    even = ($countones(r) % 2) == 0;
    return {r, even};
  endfunction

  always_comb alu_result = alu_fn(alu_command, alu_a, alu_b);

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one instruction and records the EX-cycle outputs; instr fields carry garbage while busy.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] d, input logic [2:0] sa,
                           input logic [2:0] sb, input logic [15:0] imm);
    int w;
    bit done;
    w = 0;
    done = 1'b0;
    @(negedge clk);
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%b want=1", instr_ready);
    end
    instr_valid = 1'b1;
    instr_op = op; instr_dst = d; instr_srca = sa; instr_srcb = sb; instr_imm = imm;
    @(posedge clk);
    #1;
    nex = 3;
    for (int k = 0; k < 3; k++) begin
      owv[k] = 1'b0;
      ordy[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      if (!done) begin
        oa[k] = alu_a; ob[k] = alu_b; oc[k] = alu_command;
        owv[k] = wb_valid; owa[k] = wb_addr; owd[k] = wb_data; ordy[k] = instr_ready;
        if (instr_ready) begin
          nex = k;
          done = 1'b1;
          instr_valid = 1'b0;
        end else begin
          instr_valid = 1'b1;
          instr_op = 3'($urandom); instr_dst = 3'($urandom);
          instr_srca = 3'($urandom); instr_srcb = 3'($urandom); instr_imm = 16'($urandom);
          if (k < 2) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got=%b want=0", instr_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b want=0", wb_valid); end
    checks++; if ({alu_a, alu_b, alu_command} !== 35'd0) begin errors++; $display("FAIL rst_alu got=%h want=0", {alu_a, alu_b, alu_command}); end
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b want=1", instr_ready); end
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL rst_div_err got=%b want=0", div_err); end
    checks++; if ({wb_addr, wb_data} !== 19'd0) begin errors++; $display("FAIL rst_wb_fields got=%h want=0", {wb_addr, wb_data}); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL rst_reg%0d got=%h want=0000", i, dbg_data); end
    end
  endtask

  task automatic test_ldi_add();
    run_instr(3'd5, 3'd1, 3'd0, 3'd0, 16'h000A);
    checks++; if ({owv[0], owa[0], owd[0]} !== {1'b1, 3'd1, 16'h000A}) begin errors++; $display("FAIL ldi_wb got=%h want=%h", {owv[0], owa[0], owd[0]}, {1'b1, 3'd1, 16'h000A}); end
    checks++; if ({oa[0], ob[0], oc[0]} !== 35'd0) begin errors++; $display("FAIL ldi_alu_idle got=%h want=0", {oa[0], ob[0], oc[0]}); end
    run_instr(3'd5, 3'd2, 3'd0, 3'd0, 16'h0006);
    run_instr(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000);
    checks++; if ({oa[0], ob[0], oc[0]} !== {16'h000A, 16'h0006, 3'd0}) begin errors++; $display("FAIL add_alu got=%h want=%h", {oa[0], ob[0], oc[0]}, {16'h000A, 16'h0006, 3'd0}); end
    checks++; if ({owv[0], owa[0], owd[0]} !== {1'b1, 3'd3, 16'h0010}) begin errors++; $display("FAIL add_wb got=%h want=%h", {owv[0], owa[0], owd[0]}, {1'b1, 3'd3, 16'h0010}); end
    checks++; if (nex !== 1) begin errors++; $display("FAIL add_ready_latency got=%0d want=1", nex); end
    dbg_addr = 3'd3;
    #1;
    checks++; if (dbg_data !== 16'h0010) begin errors++; $display("FAIL add_dbg_r3 got=%h want=0010", dbg_data); end
  endtask

  task automatic test_mul_wrap();
    run_instr(3'd5, 3'd7, 3'd0, 3'd0, 16'h0258);
    run_instr(3'd5, 3'd5, 3'd0, 3'd0, 16'h0190);
    run_instr(3'd3, 3'd7, 3'd7, 3'd5, 16'h0000);
    checks++; if ({oc[0], oc[1]} !== {3'd3, 3'd4}) begin errors++; $display("FAIL mul_cmds got=%h want=%h", {oc[0], oc[1]}, {3'd3, 3'd4}); end
    checks++; if ({oa[1], ob[1]} !== {16'h0258, 16'h0190}) begin errors++; $display("FAIL mul_ops_ex2 got=%h want=%h", {oa[1], ob[1]}, {16'h0258, 16'h0190}); end
    checks++; if ({owv[0], owa[0], owd[0]} !== {1'b1, 3'd7, 16'hD4C1}) begin errors++; $display("FAIL mul_wb_lo got=%h want=%h", {owv[0], owa[0], owd[0]}, {1'b1, 3'd7, 16'hD4C1}); end
    checks++; if ({owv[1], owa[1], owd[1]} !== {1'b1, 3'd0, 16'h0002}) begin errors++; $display("FAIL mul_wb_hi_wrap got=%h want=%h", {owv[1], owa[1], owd[1]}, {1'b1, 3'd0, 16'h0002}); end
    checks++; if (nex !== 2) begin errors++; $display("FAIL mul_ready_latency got=%0d want=2", nex); end
    dbg_addr = 3'd0;
    #1;
    checks++; if (dbg_data !== 16'h0002) begin errors++; $display("FAIL mul_dbg_r0 got=%h want=0002", dbg_data); end
  endtask

  task automatic test_div_zero();
    run_instr(3'd5, 3'd1, 3'd0, 3'd0, 16'h0001);
    run_instr(3'd5, 3'd4, 3'd0, 3'd0, 16'h1234);
    run_instr(3'd4, 3'd5, 3'd4, 3'd1, 16'h0000);
    checks++; if ({oa[0], ob[0], oc[0], oa[1], ob[1], oc[1]} !== 70'd0) begin errors++; $display("FAIL divz_alu_unused got=%h want=0", {oa[0], ob[0], oc[0], oa[1], ob[1], oc[1]}); end
    checks++; if ({owa[0], owd[0], owa[1], owd[1]} !== {3'd5, 16'hFFFE, 3'd6, 16'h1234}) begin errors++; $display("FAIL divz_wb got=%h want=%h", {owa[0], owd[0], owa[1], owd[1]}, {3'd5, 16'hFFFE, 3'd6, 16'h1234}); end
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL divz_err_set got=%b want=1", div_err); end
    run_instr(3'd5, 3'd3, 3'd0, 3'd0, 16'h000E);
    run_instr(3'd4, 3'd2, 3'd4, 3'd3, 16'h0000);
    checks++; if ({oc[0], oc[1], owd[0], owd[1]} !== {3'd5, 3'd6, 16'h0299, 16'h000D}) begin errors++; $display("FAIL div_normal got=%h want=%h", {oc[0], oc[1], owd[0], owd[1]}, {3'd5, 3'd6, 16'h0299, 16'h000D}); end
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL divz_err_sticky got=%b want=1", div_err); end
  endtask

  task automatic test_self_operand();
    run_instr(3'd5, 3'd1, 3'd0, 3'd0, 16'h000A);
    run_instr(3'd0, 3'd1, 3'd1, 3'd1, 16'h0000);
    checks++; if ({oa[0], ob[0]} !== {16'h000A, 16'h000A}) begin errors++; $display("FAIL self_ops got=%h want=%h", {oa[0], ob[0]}, {16'h000A, 16'h000A}); end
    checks++; if ({owv[0], owa[0], owd[0], nex} !== {1'b1, 3'd1, 16'h0015, 32'd1}) begin errors++; $display("FAIL self_wb_once got=%h want=%h", {owv[0], owa[0], owd[0], nex}, {1'b1, 3'd1, 16'h0015, 32'd1}); end
    run_instr(3'd0, 3'd2, 3'd1, 3'd1, 16'h0000);
    checks++; if ({oa[0], owd[0]} !== {16'h0015, 16'h0029}) begin errors++; $display("FAIL self_next_reads_new got=%h want=%h", {oa[0], owd[0]}, {16'h0015, 16'h0029}); end
  endtask

  task automatic test_reset_mid_div();
    run_instr(3'd5, 3'd2, 3'd0, 3'd0, 16'h0010);
    run_instr(3'd5, 3'd3, 3'd0, 3'd0, 16'h0100);
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL mid_err_before got=%b want=1", div_err); end
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = 3'd4; instr_dst = 3'd6; instr_srca = 3'd3; instr_srcb = 3'd2;
    @(posedge clk);
    #1;
    checks++; if ({instr_ready, wb_valid, wb_addr, wb_data} !== {1'b0, 1'b1, 3'd6, 16'h0020}) begin errors++; $display("FAIL mid_ex1 got=%h want=%h", {instr_ready, wb_valid, wb_addr, wb_data}, {1'b0, 1'b1, 3'd6, 16'h0020}); end
    @(posedge clk);
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL mid_ex2_ready got=%b want=0", instr_ready); end
    reset = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_no_write got=%b want=0", wb_valid); end
    @(posedge clk);
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got=%b want=0", instr_ready); end
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    checks++; if ({instr_ready, div_err} !== 2'b10) begin errors++; $display("FAIL mid_idle_after got=%b want=10", {instr_ready, div_err}); end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL mid_reg%0d got=%h want=0000", i, dbg_data); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op, d, sa, sb, d1, da;
    logic [15:0] imm, ra, rb;
    logic [15:0] ea [2], eb [2], ewd [2];
    logic [2:0]  ec [2], ewa [2];
    logic        ewv [2];
    int ne;
    do_reset();
    for (int i = 0; i < 8; i++) rm[i] = 16'h0000;
    merr = 1'b0;
    for (int n = 0; n < 120; n++) begin
      op = 3'($urandom_range(0, 7));
      d = 3'($urandom); sa = 3'($urandom); sb = 3'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom);
      ra = rm[sa]; rb = rm[sb]; d1 = d + 3'd1;
      ne = 1;
      for (int k = 0; k < 2; k++) begin
        ea[k] = '0; eb[k] = '0; ec[k] = '0; ewv[k] = 1'b0; ewa[k] = '0; ewd[k] = '0;
      end
      case (op)
        3'd0, 3'd1, 3'd2: begin
          ea[0] = ra; eb[0] = rb; ec[0] = op;
          ewv[0] = 1'b1; ewa[0] = d; ewd[0] = par(alu_fn(op, ra, rb));
        end
        3'd3: begin
          ne = 2;
          ea = '{ra, ra}; eb = '{rb, rb}; ec = '{3'd3, 3'd4};
          ewv = '{1'b1, 1'b1}; ewa = '{d, d1};
          ewd = '{par(alu_fn(3'd3, ra, rb)), par(alu_fn(3'd4, ra, rb))};
        end
        3'd4: begin
          ne = 2;
          ewv = '{1'b1, 1'b1}; ewa = '{d, d1};
          if (rb[15:1] == 15'd0) begin
            ewd = '{16'hFFFE, ra};
            merr = 1'b1;
          end else begin
            ea = '{ra, ra}; eb = '{rb, rb}; ec = '{3'd5, 3'd6};
            ewd = '{par(alu_fn(3'd5, ra, rb)), par(alu_fn(3'd6, ra, rb))};
          end
        end
        3'd5: begin
          ewv[0] = 1'b1; ewa[0] = d; ewd[0] = imm;
        end
        default: ;
      endcase
      run_instr(op, d, sa, sb, imm);
      checks++; if (nex !== ne) begin errors++; $display("FAIL rnd%0d_ready_latency op=%0d got=%0d want=%0d", n, op, nex, ne); end
      for (int k = 0; k < ne; k++) begin
        checks++;
        if ({oa[k], ob[k], oc[k], owv[k], ordy[k]} !== {ea[k], eb[k], ec[k], ewv[k], 1'b0}) begin
          errors++;
          $display("FAIL rnd%0d_ex%0d_ctrl op=%0d got=%h want=%h", n, k + 1, op, {oa[k], ob[k], oc[k], owv[k], ordy[k]}, {ea[k], eb[k], ec[k], ewv[k], 1'b0});
        end
        if (ewv[k]) begin
          checks++;
          if ({owa[k], owd[k]} !== {ewa[k], ewd[k]}) begin
            errors++;
            $display("FAIL rnd%0d_ex%0d_wb op=%0d got=%h want=%h", n, k + 1, op, {owa[k], owd[k]}, {ewa[k], ewd[k]});
          end
          rm[ewa[k]] = ewd[k];
        end
      end
      checks++; if (div_err !== merr) begin errors++; $display("FAIL rnd%0d_div_err got=%b want=%b", n, div_err, merr); end
      da = 3'($urandom);
      dbg_addr = da;
      #1;
      checks++; if (dbg_data !== rm[da]) begin errors++; $display("FAIL rnd%0d_dbg_r%0d got=%h want=%h", n, da, dbg_data, rm[da]); end
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_mul_wrap();
    test_div_zero();
    test_self_operand();
    test_reset_mid_div();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
